// File: rtl/nexys_starship_game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nexys_starship_game_ctrl_pkg
// Shared definitions for the starship game controller and its sub-modules:
//   - one-hot game state encoding (INIT / PLAY / OVER)
//   - direction indices used for monster_sm / monster_ctrl / random bit order
//   - spawn LFSR tap mask and its single-step update function
// -----------------------------------------------------------------------------
package nexys_starship_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT = 3'b001,
        ST_PLAY = 3'b010,
        ST_OVER = 3'b100
    } state_t;

    localparam logic [1:0] DIR_TOP   = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_BTM   = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam int NUM_DIR = 4;
    localparam int SCORE_W = 7;

    // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/nexys_starship_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// nexys_starship_game_ctrl_if
// Bundles the game controller's player inputs, monster-SM feedback and the
// control/status outputs.
//   master : the environment (buttons, monster SMs, display) driving inputs
//   slave  : the game controller
// Signals:
//   start_btn, fire_btn  single-cycle debounced pulses
//   fire_dir[1:0]        shot direction (top, right, bottom, left)
//   monster_sm[3:0]      monster present per direction
//   sm_gameover[3:0]     gameover flags from the monster SMs
//   play_flag, gameover_ctrl, monster_ctrl[3:0], random[3:0], timer_clk,
//   score[6:0], q_Init, q_Play, q_Over   controller outputs
// -----------------------------------------------------------------------------
interface nexys_starship_game_ctrl_if;
    import nexys_starship_game_ctrl_pkg::*;

    logic               start_btn;
    logic               fire_btn;
    logic [1:0]         fire_dir;
    logic [NUM_DIR-1:0] monster_sm;
    logic [NUM_DIR-1:0] sm_gameover;
    logic               play_flag;
    logic               gameover_ctrl;
    logic [NUM_DIR-1:0] monster_ctrl;
    logic [NUM_DIR-1:0] random;
    logic               timer_clk;
    logic [SCORE_W-1:0] score;
    logic               q_Init;
    logic               q_Play;
    logic               q_Over;

    modport master (
        output start_btn, fire_btn, fire_dir, monster_sm, sm_gameover,
        input  play_flag, gameover_ctrl, monster_ctrl, random, timer_clk,
               score, q_Init, q_Play, q_Over
    );

    modport slave (
        input  start_btn, fire_btn, fire_dir, monster_sm, sm_gameover,
        output play_flag, gameover_ctrl, monster_ctrl, random, timer_clk,
               score, q_Init, q_Play, q_Over
    );

endinterface

// File: rtl/starship_lfsr16.sv
// -----------------------------------------------------------------------------
// starship_lfsr16
// 16-bit Galois LFSR (taps from the shared package) used as the monster spawn
// randomness source. Starting from a nonzero SEED it never reaches zero.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset, loads SEED
//   i_en     advance one step on this edge
//   o_state  current 16-bit LFSR state
// -----------------------------------------------------------------------------
module starship_lfsr16
    import nexys_starship_game_ctrl_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/nexys_starship_game_ctrl.sv
// -----------------------------------------------------------------------------
// nexys_starship_game_ctrl
// Game-level controller sitting upstream of the four monster state machines.
// Runs the INIT/PLAY/OVER game FSM, keeps a saturating hit score, clears shot
// monsters through monster_ctrl, supplies per-direction spawn enables from a
// free-running LFSR and produces the slow timer_clk square wave.
// Ports:
//   Clk     system clock
//   Reset   synchronous active-high reset
//   bus     nexys_starship_game_ctrl_if.slave (buttons, monster SM feedback,
//           play_flag, gameover_ctrl, monster_ctrl, random, timer_clk, score,
//           one-hot state q_Init/q_Play/q_Over)
// -----------------------------------------------------------------------------
module nexys_starship_game_ctrl
    import nexys_starship_game_ctrl_pkg::*;
#(
    parameter int          TIMER_DIV = 50_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          SCORE_MAX = 99
) (
    input  logic Clk,
    input  logic Reset,
    nexys_starship_game_ctrl_if.slave bus
);

    localparam int                 CNT_W     = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TIMER_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_SAT = SCORE_W'(SCORE_MAX);

    state_t             r_state;
    logic [SCORE_W-1:0] r_score;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timer_clk;

    logic [15:0]        w_lfsr;
    logic               w_lfsr_unused;
    logic               w_fire_ok;
    logic [NUM_DIR-1:0] w_hit;
    logic               w_gameover;
    logic               w_score_hit;

    starship_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_en    (1'b1),
        .o_state (w_lfsr)
    );

    // Only bit pairs {4i+1, 4i} feed the spawn enables
    assign w_lfsr_unused = ^{w_lfsr[15:14], w_lfsr[11:10], w_lfsr[7:6], w_lfsr[3:2]};

    assign w_fire_ok = bus.fire_btn & (r_state == ST_PLAY);

    assign w_hit[DIR_TOP]   = w_fire_ok & (bus.fire_dir == DIR_TOP);
    assign w_hit[DIR_RIGHT] = w_fire_ok & (bus.fire_dir == DIR_RIGHT);
    assign w_hit[DIR_BTM]   = w_fire_ok & (bus.fire_dir == DIR_BTM);
    assign w_hit[DIR_LEFT]  = w_fire_ok & (bus.fire_dir == DIR_LEFT);

    assign w_gameover = |bus.sm_gameover;

    // w_hit is one-hot at most, so this is hit[fire_dir] & monster_sm[fire_dir]
    assign w_score_hit = |(w_hit & bus.monster_sm);

    // Kept combinational: the monster SMs reload from monster_ctrl every edge,
    // so a register here would lose a monster spawned in the same cycle.
    assign bus.monster_ctrl = bus.monster_sm & ~w_hit;

    for (genvar i = 0; i < NUM_DIR; i++) begin : g_random
        assign bus.random[i] = w_lfsr[4*i] & w_lfsr[4*i+1];
    end

    // Game FSM and score; gameover takes priority over a same-cycle hit
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_INIT;
            r_score <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (bus.start_btn) begin
                        r_state <= ST_PLAY;
                        r_score <= '0;
                    end
                end
                ST_PLAY: begin
                    if (w_gameover) begin
                        r_state <= ST_OVER;
                    end else if (w_score_hit && (r_score < SCORE_SAT)) begin
                        r_score <= r_score + SCORE_W'(1);
                    end
                end
                ST_OVER: begin
                    if (bus.start_btn) begin
                        r_state <= ST_INIT;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Free-running half-period divider for timer_clk
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt       <= '0;
            r_timer_clk <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt       <= '0;
            r_timer_clk <= ~r_timer_clk;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.q_Init        = r_state[0];
    assign bus.q_Play        = r_state[1];
    assign bus.q_Over        = r_state[2];
    assign bus.play_flag     = r_state[1];
    assign bus.gameover_ctrl = r_state[2];
    assign bus.score         = r_score;
    assign bus.timer_clk     = r_timer_clk;

endmodule

// File: tb/tb_nexys_starship_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nexys_starship_game_ctrl
// Self-checking bench for nexys_starship_game_ctrl with TIMER_DIV = 4.
// A behavioural game model tracks state, score, LFSR value and divider; a
// vector table covers the FSM/score/hit rules and hand sequences cover reset,
// the timer period, score saturation and reset in mid-game, followed by
// randomized play.
// -----------------------------------------------------------------------------
module tb_nexys_starship_game_ctrl;

    localparam int          TDIV = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic Clk = 1'b0;
    logic Reset;

    nexys_starship_game_ctrl_if bus ();

    nexys_starship_game_ctrl #(
        .TIMER_DIV (TDIV),
        .LFSR_SEED (SEED),
        .SCORE_MAX (99)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state 0 = INIT, 1 = PLAY, 2 = OVER
    int          m_state;
    int          m_score;
    logic [15:0] m_lfsr;
    int          m_cnt;
    logic        m_tclk;
    bit          m_valid = 0;

    typedef struct {
        logic       start;
        logic       fire;
        logic [1:0] dir;
        logic [3:0] msm;
        logic [3:0] gov;
        logic [3:0] exp_mctrl;
        logic [2:0] exp_q;
        logic [6:0] exp_score;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic start, input logic fire,
                              input logic [1:0] dir, input logic [3:0] msm,
                              input logic [3:0] gov);
        if (rst) begin
            m_state = 0;
            m_score = 0;
            m_lfsr  = SEED;
            m_cnt   = 0;
            m_tclk  = 0;
            return;
        end
        if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
        else                 m_lfsr = m_lfsr >> 1;
        if (m_cnt == TDIV - 1) begin
            m_cnt  = 0;
            m_tclk = !m_tclk;
        end else begin
            m_cnt = m_cnt + 1;
        end
        case (m_state)
            0: if (start) begin m_state = 1; m_score = 0; end
            1: begin
                if (gov != 0) m_state = 2;
                else if (fire && msm[dir]) m_score = (m_score < 99) ? m_score + 1 : 99;
            end
            default: if (start) m_state = 0;
        endcase
    endtask

    function automatic logic [3:0] exp_random(input logic [15:0] l);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = l[4*i] & l[4*i+1];
        return r;
    endfunction

    task automatic chk_regs();
        logic [2:0] q_exp;
        q_exp = 3'(1 << m_state);
        chk("state_onehot", {bus.q_Over, bus.q_Play, bus.q_Init}, q_exp);
        chk("play_flag", bus.play_flag, (m_state == 1));
        chk("gameover_ctrl", bus.gameover_ctrl, (m_state == 2));
        chk("score", bus.score, m_score);
        chk("timer_clk", bus.timer_clk, m_tclk);
        chk("random", bus.random, exp_random(m_lfsr));
        chk("lfsr", dut.w_lfsr, m_lfsr);
    endtask

    // Drives one cycle of inputs, checks the combinational monster_ctrl before
    // the edge, advances the model on the edge and checks registered outputs.
    task automatic cycle(input logic rst, input logic start, input logic fire,
                         input logic [1:0] dir, input logic [3:0] msm,
                         input logic [3:0] gov, output logic [3:0] mc_pre);
        logic [3:0] mc_exp;
        Reset           = rst;
        bus.start_btn   = start;
        bus.fire_btn    = fire;
        bus.fire_dir    = dir;
        bus.monster_sm  = msm;
        bus.sm_gameover = gov;
        #2;
        mc_pre = bus.monster_ctrl;
        if (m_valid) begin
            mc_exp = msm;
            if (fire && m_state == 1) mc_exp[dir] = 1'b0;
            chk("monster_ctrl", mc_pre, mc_exp);
        end
        @(posedge Clk);
        model_step(rst, start, fire, dir, msm, gov);
        m_valid = 1;
        #1;
        chk_regs();
    endtask

    task automatic idle(input logic rst);
        logic [3:0] mc;
        cycle(rst, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, mc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mc;
        int         rcnt[4];
        logic       r_rst, r_start, r_fire;
        logic [1:0] r_dir;
        logic [3:0] r_msm, r_gov;

        vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 3'b010, 7'd0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 3'b010, 7'd0};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b0000, 3'b010, 7'd1};
        vecs[3]  = '{1'b0, 1'b1, 2'd0, 4'b0100, 4'b0000, 4'b0100, 3'b010, 7'd1};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 4'b0000, 3'b010, 7'd2};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 4'b1111, 4'b0000, 4'b0111, 3'b010, 7'd3};
        vecs[6]  = '{1'b0, 1'b0, 2'd1, 4'b1010, 4'b0000, 4'b1010, 3'b010, 7'd3};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100, 4'b0000, 3'b100, 7'd3};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b0100, 3'b100, 7'd3};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 3'b001, 7'd3};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 4'b0010, 3'b001, 7'd3};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 3'b010, 7'd0};

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("reset_q_init", bus.q_Init, 1'b1);
        chk("reset_score", bus.score, 7'd0);
        chk("reset_timer_clk", bus.timer_clk, 1'b0);
        chk("reset_lfsr_seed", dut.w_lfsr, 16'hACE1);

        // timer_clk first toggles on the 4th edge after release
        for (int k = 1; k <= 4; k++) begin
            idle(1'b0);
            chk("timer_first_toggle", bus.timer_clk, (k == 4));
        end

        // Table-driven FSM / hit / score rules
        for (int v = 0; v < 12; v++) begin
            cycle(1'b0, vecs[v].start, vecs[v].fire, vecs[v].dir, vecs[v].msm,
                  vecs[v].gov, mc);
            chk("vec_monster_ctrl", mc, vecs[v].exp_mctrl);
            chk("vec_state", {bus.q_Over, bus.q_Play, bus.q_Init}, vecs[v].exp_q);
            chk("vec_score", bus.score, vecs[v].exp_score);
        end

        // Score saturation at 99 (now in PLAY with score 0)
        for (int h = 0; h < 99; h++) cycle(1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'h0, mc);
        chk("score_reach_99", bus.score, 7'd99);
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'h0, mc);
        chk("score_saturate", bus.score, 7'd99);

        // Reset in mid-game with score 5
        idle(1'b1);
        cycle(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, mc);
        for (int h = 0; h < 5; h++) cycle(1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 4'h0, mc);
        chk("midgame_score5", bus.score, 7'd5);
        idle(1'b1);
        chk("midreset_q", {bus.q_Over, bus.q_Play, bus.q_Init}, 3'b001);
        chk("midreset_score", bus.score, 7'd0);
        chk("midreset_timer", bus.timer_clk, 1'b0);
        chk("midreset_lfsr", dut.w_lfsr, 16'hACE1);

        // Randomized play against the model
        for (int i = 0; i < 4; i++) rcnt[i] = 0;
        for (int n = 0; n < 1000; n++) begin
            r_rst   = ($urandom_range(199) == 0);
            r_start = ($urandom_range(7) == 0);
            r_fire  = ($urandom_range(2) == 0);
            r_dir   = 2'($urandom_range(3));
            r_msm   = 4'($urandom);
            r_gov   = ($urandom_range(31) == 0) ? 4'($urandom) : 4'h0;
            cycle(r_rst, r_start, r_fire, r_dir, r_msm, r_gov, mc);
            chk("lfsr_nonzero", (dut.w_lfsr != 16'h0), 1'b1);
            for (int i = 0; i < 4; i++) rcnt[i] += int'(bus.random[i]);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("random_rate_dir%0d_in_150_350", i),
                (rcnt[i] >= 150 && rcnt[i] <= 350), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
